// File: rtl/design_b_pkg.sv
`default_nettype none
// ============================================================================
// Module      : design_b_pkg
// Description : Shared encodings, widths and helpers for the design_b
//               accumulator microcontroller (instruction fields, flag and
//               core state enums, saturation helper).
// Ports       : none (package)
// Revision    : 1.0  initial release
// ============================================================================
package design_b_pkg;

    localparam int DATA_W     = 11;
    localparam int INSTR_W    = 20;
    localparam int IMEM_DEPTH = 64;
    localparam int PC_W       = 6;
    // Wide enough for the full-precision product of two 11-bit operands.
    localparam int WIDE_W     = 24;
    // Sleep counts are saturated to SAT_MAX, so 10 bits suffice.
    localparam int SLP_W      = 10;

    localparam logic signed [DATA_W-1:0] SAT_MAX  = 11'sd999;
    localparam logic signed [DATA_W-1:0] SAT_MIN  = -11'sd999;
    localparam logic signed [DATA_W-1:0] NOT_TRUE = 11'sd100;

    // Condition field [19:18]
    localparam logic [1:0] COND_ALWAYS  = 2'b00;
    localparam logic [1:0] COND_PLUS    = 2'b01;
    localparam logic [1:0] COND_MINUS   = 2'b10;
    localparam logic [1:0] COND_ALWAYS2 = 2'b11;

    // Source field [13:12]
    localparam logic [1:0] SRC_IMM = 2'b00;
    localparam logic [1:0] SRC_ACC = 2'b01;
    localparam logic [1:0] SRC_DAT = 2'b10;
    localparam logic [1:0] SRC_IN  = 2'b11;

    // Opcode field [17:14]; 14 and 15 decode as NOP.
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_MOVA = 4'd1;
    localparam logic [3:0] OP_MOVD = 4'd2;
    localparam logic [3:0] OP_MOVO = 4'd3;
    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd5;
    localparam logic [3:0] OP_MUL  = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_TEQ  = 4'd8;
    localparam logic [3:0] OP_TGT  = 4'd9;
    localparam logic [3:0] OP_TLT  = 4'd10;
    localparam logic [3:0] OP_SLP  = 4'd11;
    localparam logic [3:0] OP_JMP  = 4'd12;
    localparam logic [3:0] OP_END  = 4'd13;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        PLUS  = 2'd1,
        MINUS = 2'd2
    } flag_t;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        SLEEP = 1'b1
    } core_state_t;

    // Clamp a full-precision result into [SAT_MIN, SAT_MAX].
    function automatic logic signed [DATA_W-1:0] sat(input logic signed [WIDE_W-1:0] v);
        if (v > WIDE_W'(SAT_MAX)) begin
            return SAT_MAX;
        end
        if (v < WIDE_W'(SAT_MIN)) begin
            return SAT_MIN;
        end
        return v[DATA_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/design_b_if.sv
`default_nettype none
// ============================================================================
// Module      : design_b_if
// Description : Pin bundle of the microcontroller: big-clock tick, input
//               pin p0 and output pin p1.
// Ports       : posedge_big_clk (tick), input_signal (p0), output_signal (p1)
//               master = environment side, slave = design side
// Revision    : 1.0  initial release
// ============================================================================
interface design_b_if;
    import design_b_pkg::*;

    logic                     posedge_big_clk;
    logic signed [DATA_W-1:0] input_signal;
    logic signed [DATA_W-1:0] output_signal;

    modport master (
        output posedge_big_clk,
        output input_signal,
        input  output_signal
    );

    modport slave (
        input  posedge_big_clk,
        input  input_signal,
        output output_signal
    );
endinterface
`default_nettype wire

// File: rtl/design_b_core.sv
`default_nettype none
// ============================================================================
// Module      : mcu_core
// Description : Accumulator core: fetch/decode/execute one instruction per
//               clk while in RUN, sleep counter driven by big-clock ticks.
// Ports       : clk, rst_n, i_tick (big-clock tick), i_input (p0),
//               o_out_we / o_out_data (output pin write request)
// Revision    : 1.0  initial release
// ============================================================================
module mcu_core
    import design_b_pkg::*;
(
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     i_tick,
    input  wire logic signed [DATA_W-1:0] i_input,
    output logic                          o_out_we,
    output logic signed [DATA_W-1:0]      o_out_data
);
    logic [PC_W-1:0]          r_pc,        w_pc_next;
    logic signed [DATA_W-1:0] r_acc,       w_acc_next;
    logic signed [DATA_W-1:0] r_dat,       w_dat_next;
    flag_t                    r_flag,      w_flag_next;
    core_state_t              r_state,     w_state_next;
    logic [SLP_W-1:0]         r_sleep_cnt, w_sleep_cnt_next;

    logic [INSTR_W-1:0]       w_instr;
    logic [1:0]               w_cond;
    logic [3:0]               w_op;
    logic [1:0]               w_src_sel;
    logic signed [DATA_W-1:0] w_imm;
    logic                     w_unused_bit;
    logic signed [DATA_W-1:0] w_src;
    logic signed [DATA_W-1:0] w_src_sat;
    logic signed [WIDE_W-1:0] w_acc_wide;
    logic signed [WIDE_W-1:0] w_src_wide;
    logic                     w_run;

    instr_mem instructionMemory (
        .i_addr (r_pc),
        .o_data (w_instr)
    );

    assign w_cond       = w_instr[19:18];
    assign w_op         = w_instr[17:14];
    assign w_src_sel    = w_instr[13:12];
    assign w_unused_bit = w_instr[11];
    assign w_imm        = w_instr[10:0];

    always_comb begin
        w_src = w_imm;
        unique case (w_src_sel)
            SRC_IMM: w_src = w_imm;
            SRC_ACC: w_src = r_acc;
            SRC_DAT: w_src = r_dat;
            SRC_IN:  w_src = i_input;
            default: w_src = w_imm;
        endcase
    end

    // Raw immediates and the input pin span +/-1024, so moves clamp too.
    assign w_src_wide = WIDE_W'(w_src);
    assign w_acc_wide = WIDE_W'(r_acc);
    assign w_src_sat  = sat(w_src_wide);

    assign w_run = (w_cond == COND_PLUS)  ? (r_flag == PLUS)  :
                   (w_cond == COND_MINUS) ? (r_flag == MINUS) : 1'b1;

    always_comb begin
        w_pc_next        = r_pc + PC_W'(1);
        w_acc_next       = r_acc;
        w_dat_next       = r_dat;
        w_flag_next      = r_flag;
        w_state_next     = r_state;
        w_sleep_cnt_next = r_sleep_cnt;
        o_out_we         = 1'b0;
        o_out_data       = w_src_sat;

        unique case (r_state)
            RUN: begin
                if (w_run) begin
                    unique case (w_op)
                        OP_MOVA: w_acc_next = w_src_sat;
                        OP_MOVD: w_dat_next = w_src_sat;
                        OP_MOVO: o_out_we   = 1'b1;
                        OP_ADD:  w_acc_next = sat(w_acc_wide + w_src_wide);
                        OP_SUB:  w_acc_next = sat(w_acc_wide - w_src_wide);
                        OP_MUL:  w_acc_next = sat(w_acc_wide * w_src_wide);
                        OP_NOT:  w_acc_next = (r_acc == '0) ? NOT_TRUE : '0;
                        OP_TEQ:  w_flag_next = (r_acc == w_src) ? PLUS : MINUS;
                        OP_TGT:  w_flag_next = (r_acc >  w_src) ? PLUS : MINUS;
                        OP_TLT:  w_flag_next = (r_acc <  w_src) ? PLUS : MINUS;
                        OP_SLP: begin
                            // Non-positive counts fall through as a NOP.
                            if (!w_src_sat[DATA_W-1] && (w_src_sat != '0)) begin
                                w_state_next     = SLEEP;
                                w_sleep_cnt_next = w_src_sat[SLP_W-1:0];
                            end
                        end
                        OP_JMP:  w_pc_next = w_imm[PC_W-1:0];
                        OP_END:  w_pc_next = '0;
                        default: ;
                    endcase
                end
            end
            SLEEP: begin
                // pc already points past the SLP; hold it until wake-up.
                w_pc_next = r_pc;
                if (i_tick) begin
                    w_sleep_cnt_next = r_sleep_cnt - SLP_W'(1);
                    if (r_sleep_cnt == SLP_W'(1)) begin
                        w_state_next = RUN;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= '0;
            r_acc       <= '0;
            r_dat       <= '0;
            r_flag      <= NONE;
            r_state     <= RUN;
            r_sleep_cnt <= '0;
        end else begin
            r_pc        <= w_pc_next;
            r_acc       <= w_acc_next;
            r_dat       <= w_dat_next;
            r_flag      <= w_flag_next;
            r_state     <= w_state_next;
            r_sleep_cnt <= w_sleep_cnt_next;
        end
    end
endmodule
`default_nettype wire

// File: rtl/design_b_imem.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem
// Description : Instruction store, asynchronous read, no write port. The
//               array is loaded externally through its hierarchical name.
// Ports       : i_addr (program counter), o_data (instruction word)
// Revision    : 1.0  initial release
// ============================================================================
module instr_mem
    import design_b_pkg::*;
(
    input  wire logic [PC_W-1:0]    i_addr,
    output logic      [INSTR_W-1:0] o_data
);
    logic [INSTR_W-1:0] memory [0:IMEM_DEPTH-1];

    assign o_data = memory[i_addr];
endmodule
`default_nettype wire

// File: rtl/design_b.sv
`default_nettype none
// ============================================================================
// Module      : design_b
// Description : Single-microcontroller wrapper: passes the tick and input
//               pin to the core and registers the output pin.
// Ports       : clk, rst_n (async, active-low), io (design_b_if.slave:
//               posedge_big_clk, input_signal, output_signal)
// Revision    : 1.0  initial release
// ============================================================================
module design_b
    import design_b_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst_n,
    design_b_if.slave   io
);
    logic                     w_out_we;
    logic signed [DATA_W-1:0] w_out_data;
    logic signed [DATA_W-1:0] r_output;

    mcu_core dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_tick     (io.posedge_big_clk),
        .i_input    (io.input_signal),
        .o_out_we   (w_out_we),
        .o_out_data (w_out_data)
    );

    // A MOVO becomes visible on the pin the cycle after it executes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_output <= '0;
        end else if (w_out_we) begin
            r_output <= w_out_data;
        end
    end

    assign io.output_signal = r_output;
endmodule
`default_nettype wire

// File: tb/tb_design_b.sv
`default_nettype none
// ============================================================================
// Module      : tb_design_b
// Description : Self-checking bench for design_b: directed scenarios plus
//               random programs compared cycle by cycle with an
//               instruction-level reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_design_b;
    logic              clk;
    logic              rst_n;
    logic              tick;
    logic signed [10:0] inp;
    int                checks;
    int                errors;

    logic [19:0] prog [64];

    // Reference model state
    int m_pc, m_acc, m_dat, m_flag, m_sleep, m_out;

    design_b_if bus ();
    assign bus.posedge_big_clk = tick;
    assign bus.input_signal    = inp;

    design_b dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach summary, got timeout, required completion");
        $fatal(1);
    end

    function automatic logic [19:0] ins(input int c, input int op, input int s, input int imm);
        logic [10:0] im;
        logic [1:0]  cc;
        logic [3:0]  oo;
        logic [1:0]  ss;
        im = imm[10:0];
        cc = c[1:0];
        oo = op[3:0];
        ss = s[1:0];
        return {cc, oo, ss, 1'b0, im};
    endfunction

    function automatic int sx(input logic [10:0] v);
        return int'($signed(v));
    endfunction

    function automatic int clamp(input int v);
        if (v > 999)  return 999;
        if (v < -999) return -999;
        return v;
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) prog[i] = '0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 64; i++) dut.dut2.instructionMemory.memory[i] = prog[i];
    endtask

    task automatic model_reset();
        m_pc = 0; m_acc = 0; m_dat = 0; m_flag = 0; m_sleep = 0; m_out = 0;
    endtask

    // One clk edge of the instruction-level machine.
    task automatic model_step();
        logic [19:0] w;
        int  srcv, nxt;
        bit  go;
        if (m_sleep > 0) begin
            if (tick) m_sleep = m_sleep - 1;
            return;
        end
        w   = prog[m_pc];
        go  = (w[19:18] == 2'b01) ? (m_flag == 1) :
              (w[19:18] == 2'b10) ? (m_flag == 2) : 1'b1;
        nxt = (m_pc + 1) % 64;
        if (go) begin
            case (w[13:12])
                2'd0:    srcv = sx(w[10:0]);
                2'd1:    srcv = m_acc;
                2'd2:    srcv = m_dat;
                default: srcv = int'(inp);
            endcase
            case (int'(w[17:14]))
                1:  m_acc = clamp(srcv);
                2:  m_dat = clamp(srcv);
                3:  m_out = clamp(srcv);
                4:  m_acc = clamp(m_acc + srcv);
                5:  m_acc = clamp(m_acc - srcv);
                6:  m_acc = clamp(m_acc * srcv);
                7:  m_acc = (m_acc == 0) ? 100 : 0;
                8:  m_flag = (m_acc == srcv) ? 1 : 2;
                9:  m_flag = (m_acc >  srcv) ? 1 : 2;
                10: m_flag = (m_acc <  srcv) ? 1 : 2;
                11: if (clamp(srcv) > 0) m_sleep = clamp(srcv);
                12: nxt = int'(w[5:0]);
                13: nxt = 0;
                default: ;
            endcase
        end
        m_pc = nxt;
    endtask

    task automatic do_reset();
        tick  = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input logic t);
        tick = t;
        @(posedge clk);
        model_step();
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic test_reset();
        clear_prog();
        prog[0] = ins(0, 3, 3, 0);
        prog[1] = ins(0, 12, 0, 0);
        load_prog();
        inp   = 11'sd5;
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick = (i % 2 == 0);
            @(negedge clk);
        end
        tick = 1'b0;
        checks++;
        if (bus.output_signal !== 11'sd0) begin
            errors++;
            $display("FAIL reset_output: got %0d, required 0", bus.output_signal);
        end
        checks++;
        if (dut.dut2.r_pc !== 6'd0) begin
            errors++;
            $display("FAIL reset_pc: got %0d, required 0", dut.dut2.r_pc);
        end
        model_reset();
        rst_n = 1'b1;
        step(1'b0);
        checks++;
        if (bus.output_signal !== 11'sd5) begin
            errors++;
            $display("FAIL reset_first_exec: got %0d, required 5", bus.output_signal);
        end
    endtask

    task automatic test_saturation();
        clear_prog();
        prog[0] = ins(0, 1, 0, 500);
        prog[1] = ins(0, 4, 0, 700);
        prog[2] = ins(0, 3, 1, 0);
        prog[3] = ins(0, 11, 0, 1);
        load_prog();
        do_reset();
        step(1'b0);
        step(1'b0);
        checks++;
        if (bus.output_signal !== 11'sd0) begin
            errors++;
            $display("FAIL sat_before_movo: got %0d, required 0", bus.output_signal);
        end
        step(1'b0);
        checks++;
        if (bus.output_signal !== 11'sd999) begin
            errors++;
            $display("FAIL sat_add_pos: got %0d, required 999", bus.output_signal);
        end

        clear_prog();
        prog[0] = ins(0, 1, 0, 500);
        prog[1] = ins(0, 6, 0, -3);
        prog[2] = ins(0, 3, 1, 0);
        prog[3] = ins(0, 3, 0, 1023);
        prog[4] = ins(0, 3, 0, -1024);
        prog[5] = ins(0, 13, 0, 0);
        load_prog();
        do_reset();
        repeat (3) step(1'b0);
        checks++;
        if (bus.output_signal !== -11'sd999) begin
            errors++;
            $display("FAIL sat_mul_neg: got %0d, required -999", bus.output_signal);
        end
        step(1'b0);
        checks++;
        if (bus.output_signal !== 11'sd999) begin
            errors++;
            $display("FAIL sat_mov_imm_max: got %0d, required 999", bus.output_signal);
        end
        step(1'b0);
        checks++;
        if (bus.output_signal !== -11'sd999) begin
            errors++;
            $display("FAIL sat_mov_imm_min: got %0d, required -999", bus.output_signal);
        end
    endtask

    task automatic test_slp_period();
        logic signed [10:0] prev;
        int seg_ticks, segs;
        bit started;
        clear_prog();
        prog[0] = ins(0, 3, 0, 50);
        prog[1] = ins(0, 11, 0, 2);
        prog[2] = ins(0, 3, 0, 0);
        prog[3] = ins(0, 11, 0, 2);
        prog[4] = ins(0, 12, 0, 0);
        load_prog();
        do_reset();
        seg_ticks = 0;
        segs      = 0;
        started   = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            prev = bus.output_signal;
            if (k % 4 == 3) seg_ticks++;
            step(k % 4 == 3);
            if (bus.output_signal !== prev) begin
                checks++;
                if (bus.output_signal !== ((prev == 11'sd50) ? 11'sd0 : 11'sd50)) begin
                    errors++;
                    $display("FAIL slp_alternate: got %0d, required %0d", bus.output_signal,
                             (prev == 11'sd50) ? 0 : 50);
                end
                if (started) begin
                    segs++;
                    checks++;
                    if (seg_ticks != 2) begin
                        errors++;
                        $display("FAIL slp_ticks_per_value: got %0d ticks, required 2", seg_ticks);
                    end
                end
                started   = 1'b1;
                seg_ticks = 0;
            end
        end
        checks++;
        if (segs < 6) begin
            errors++;
            $display("FAIL slp_segments: got %0d segments, required at least 6", segs);
        end
    endtask

    task automatic test_tgt_cond();
        clear_prog();
        prog[0] = ins(0, 1, 0, 10);
        prog[1] = ins(0, 9, 3, 0);
        prog[2] = ins(1, 3, 0, 100);
        prog[3] = ins(2, 3, 0, 7);
        prog[4] = ins(0, 12, 0, 1);
        load_prog();
        inp = 11'sd30;
        do_reset();
        repeat (3) step(1'b0);
        checks++;
        if (bus.output_signal !== 11'sd0) begin
            errors++;
            $display("FAIL tgt_plus_skipped: got %0d, required 0", bus.output_signal);
        end
        step(1'b0);
        checks++;
        if (bus.output_signal !== 11'sd7) begin
            errors++;
            $display("FAIL tgt_minus_exec: got %0d, required 7", bus.output_signal);
        end
        inp = 11'sd5;
        repeat (3) step(1'b0);
        checks++;
        if (bus.output_signal !== 11'sd100) begin
            errors++;
            $display("FAIL tgt_plus_exec: got %0d, required 100", bus.output_signal);
        end
        repeat (6) step(1'b0);
        checks++;
        if (bus.output_signal !== 11'sd100) begin
            errors++;
            $display("FAIL tgt_minus_skipped: got %0d, required 100", bus.output_signal);
        end
    endtask

    task automatic test_tick_in_slp_cycle();
        clear_prog();
        prog[0] = ins(0, 11, 0, 1);
        prog[1] = ins(0, 3, 0, 77);
        prog[2] = ins(0, 12, 0, 2);
        load_prog();
        do_reset();
        step(1'b1);
        repeat (199) step(1'b0);
        checks++;
        if (bus.output_signal !== 11'sd0) begin
            errors++;
            $display("FAIL slp_same_cycle_tick: got %0d, required 0 (still asleep)", bus.output_signal);
        end
        step(1'b1);
        checks++;
        if (bus.output_signal !== 11'sd0) begin
            errors++;
            $display("FAIL slp_wake_latency: got %0d, required 0", bus.output_signal);
        end
        step(1'b0);
        checks++;
        if (bus.output_signal !== 11'sd77) begin
            errors++;
            $display("FAIL slp_wake_exec: got %0d, required 77", bus.output_signal);
        end
    endtask

    task automatic test_mov_not_slp0();
        clear_prog();
        prog[0] = ins(0, 1, 3, 0);
        prog[1] = ins(0, 2, 1, 0);
        prog[2] = ins(0, 3, 2, 0);
        prog[3] = ins(0, 1, 0, 0);
        prog[4] = ins(0, 7, 0, 0);
        prog[5] = ins(0, 3, 1, 0);
        prog[6] = ins(0, 11, 0, 0);
        prog[7] = ins(0, 3, 0, 5);
        prog[8] = ins(0, 12, 0, 8);
        load_prog();
        inp = -11'sd42;
        do_reset();
        repeat (3) step(1'b0);
        checks++;
        if (bus.output_signal !== -11'sd42) begin
            errors++;
            $display("FAIL mov_chain: got %0d, required -42", bus.output_signal);
        end
        repeat (3) step(1'b0);
        checks++;
        if (bus.output_signal !== 11'sd100) begin
            errors++;
            $display("FAIL not_zero: got %0d, required 100", bus.output_signal);
        end
        repeat (2) step(1'b0);
        checks++;
        if (bus.output_signal !== 11'sd5) begin
            errors++;
            $display("FAIL slp_zero_nostall: got %0d, required 5", bus.output_signal);
        end
    endtask

    task automatic test_reset_mid_sleep();
        clear_prog();
        prog[0] = ins(0, 3, 0, 9);
        prog[1] = ins(0, 11, 0, 5);
        prog[2] = ins(0, 3, 0, 3);
        prog[3] = ins(0, 12, 0, 2);
        load_prog();
        do_reset();
        repeat (4) step(1'b0);
        checks++;
        if (bus.output_signal !== 11'sd9) begin
            errors++;
            $display("FAIL midsleep_pre: got %0d, required 9", bus.output_signal);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.output_signal !== 11'sd0) begin
            errors++;
            $display("FAIL midsleep_async_clear: got %0d, required 0", bus.output_signal);
        end
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        step(1'b0);
        checks++;
        if (bus.output_signal !== 11'sd9) begin
            errors++;
            $display("FAIL midsleep_aborted: got %0d, required 9", bus.output_signal);
        end
        step(1'b0);
        repeat (5) step(1'b1);
        step(1'b0);
        checks++;
        if (bus.output_signal !== 11'sd3) begin
            errors++;
            $display("FAIL midsleep_fresh_count: got %0d, required 3", bus.output_signal);
        end
    endtask

    task automatic test_random();
        int op, c, s, imm;
        logic signed [10:0] exp_out;
        for (int p = 0; p < 4; p++) begin
            clear_prog();
            for (int i = 0; i < 16; i++) begin
                op  = $urandom_range(0, 15);
                c   = $urandom_range(0, 3);
                s   = $urandom_range(0, 3);
                imm = int'($urandom_range(0, 2047)) - 1024;
                if (op == 11) begin
                    s   = 0;
                    imm = int'($urandom_range(0, 4)) - 1;
                end
                if (op == 12) imm = $urandom_range(0, 16);
                prog[i] = ins(c, op, s, imm);
            end
            prog[16] = ins(0, 12, 0, 0);
            load_prog();
            inp = 11'sd0;
            do_reset();
            for (int k = 0; k < 250; k++) begin
                inp = 11'(int'($urandom_range(0, 2047)) - 1024);
                step($urandom_range(0, 2) == 0);
                exp_out = m_out[10:0];
                checks++;
                if (bus.output_signal !== exp_out) begin
                    errors++;
                    $display("FAIL random_p%0d_c%0d: got %0d, required %0d", p, k,
                             bus.output_signal, exp_out);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        tick   = 1'b0;
        inp    = 11'sd0;
        rst_n  = 1'b0;
        test_reset();
        test_saturation();
        test_slp_period();
        test_tgt_cond();
        test_tick_in_slp_cycle();
        test_mov_not_slp0();
        test_reset_mid_sleep();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
